// File: rtl/nand2_ate_seq.sv
`timescale 1ns/1ps
// ATE service-mode sequencer: sweeps the four i0/i1 vectors across a bank of NAND2
// bricks, samples each lane after a settle time and accumulates per-lane failures.
module nand2_ate_seq #(
    parameter int unsigned LANES  = 8,
    parameter int unsigned SETTLE = 3,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             CELCLK,
    input  logic             CELRST,
    input  logic             start,
    input  logic             abort,
    input  logic [LANES-1:0] gate_o,
    output logic [LANES-1:0] gate_i0,
    output logic [LANES-1:0] gate_i1,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [LANES-1:0] fail_mask,
    output logic [CNT_W-1:0] err_cnt,
    output logic [1:0]       vec_idx
);

    localparam int unsigned SC_W = 8;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_APPLY  = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_SAMPLE = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]       r_state;
    logic [SC_W-1:0]  r_settle_cnt;
    logic [1:0]       r_vec_idx;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [LANES-1:0] r_gate_i0;
    logic [LANES-1:0] r_gate_i1;
    logic [LANES-1:0] r_fail_mask;
    logic [CNT_W-1:0] r_err_cnt;

    logic [2:0]       w_state_nxt;
    logic [1:0]       w_vec_nxt;
    logic             w_clear;
    logic             w_upd;
    logic             w_busy_nxt;
    logic [LANES-1:0] w_exp;
    logic [LANES-1:0] w_diff;
    logic [LANES-1:0] w_mask_nxt;
    logic [CNT_W:0]   w_pop;
    logic [CNT_W:0]   w_sum;
    logic [CNT_W-1:0] w_cnt_nxt;

    // Next state, vector index and result accumulation
    always_comb begin
        w_state_nxt = r_state;
        w_vec_nxt   = r_vec_idx;
        w_clear     = 1'b0;
        w_upd       = 1'b0;
        w_busy_nxt  = 1'b0;
        w_exp       = '0;
        w_diff      = '0;
        w_mask_nxt  = r_fail_mask;
        w_pop       = '0;
        w_sum       = '0;
        w_cnt_nxt   = r_err_cnt;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt = S_APPLY;
                    w_vec_nxt   = 2'd0;
                    w_clear     = 1'b1;
                end
            end
            S_APPLY: begin
                w_state_nxt = abort ? S_IDLE : S_SETTLE;
            end
            S_SETTLE: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_settle_cnt == '0) begin
                    w_state_nxt = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_upd = 1'b1;
                    if (r_vec_idx == 2'd3) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_APPLY;
                        w_vec_nxt   = r_vec_idx + 2'd1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        w_busy_nxt = (w_state_nxt == S_APPLY) || (w_state_nxt == S_SETTLE) ||
                     (w_state_nxt == S_SAMPLE);

        // A healthy NAND2 outputs 0 only when both inputs are 1 (vector 3)
        w_exp  = (r_vec_idx == 2'd3) ? '0 : '1;
        w_diff = gate_o ^ w_exp;
        for (int k = 0; k < int'(LANES); k++) begin
            w_pop = w_pop + (CNT_W+1)'(w_diff[k]);
        end
        w_sum = {1'b0, r_err_cnt} + w_pop;

        if (w_clear) begin
            w_mask_nxt = '0;
            w_cnt_nxt  = '0;
        end else if (w_upd) begin
            w_mask_nxt = r_fail_mask | w_diff;
            w_cnt_nxt  = w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge CELCLK or posedge CELRST) begin
        if (CELRST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered outputs follow the state being entered
    always_ff @(posedge CELCLK or posedge CELRST) begin
        if (CELRST) begin
            r_settle_cnt <= '0;
            r_vec_idx    <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_gate_i0    <= '0;
            r_gate_i1    <= '0;
            r_fail_mask  <= '0;
            r_err_cnt    <= '0;
        end else begin
            if ((w_state_nxt == S_SETTLE) && (r_state != S_SETTLE)) begin
                r_settle_cnt <= SC_W'(SETTLE - 1);
            end else if ((r_state == S_SETTLE) && (r_settle_cnt != '0)) begin
                r_settle_cnt <= r_settle_cnt - SC_W'(1);
            end
            r_vec_idx   <= w_vec_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= (w_state_nxt == S_DONE);
            r_pass      <= (w_state_nxt == S_DONE) && (w_mask_nxt == '0);
            r_gate_i0   <= w_busy_nxt ? {LANES{w_vec_nxt[1]}} : '0;
            r_gate_i1   <= w_busy_nxt ? {LANES{w_vec_nxt[0]}} : '0;
            r_fail_mask <= w_mask_nxt;
            r_err_cnt   <= w_cnt_nxt;
        end
    end

    assign gate_i0   = r_gate_i0;
    assign gate_i1   = r_gate_i1;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign fail_mask = r_fail_mask;
    assign err_cnt   = r_err_cnt;
    assign vec_idx   = r_vec_idx;

endmodule
